// File: rtl/clk_divider_prog.sv
// Fully synchronous clock-enable generator: a free-running power-of-two bank plus
// a programmable divide-by-N channel whose ratio changes only at period boundaries.
module clk_divider_prog #(
  parameter int STAGES      = 4,
  parameter int CNT_W       = 8,
  parameter int DEFAULT_DIV = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CNT_W-1:0]  div_val,
  input  logic              div_load,
  output logic [STAGES-1:0] div_pow,
  output logic              prog_clk,
  output logic              prog_tick,
  output logic              div_pending,
  output logic              div_err,
  output logic [CNT_W-1:0]  div_active
);

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  localparam logic [CNT_W-1:0] DEF_RATIO = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
  localparam int               HW        = CNT_W + 1;

  state_t           state;
  logic [CNT_W-1:0] shadow;
  logic [CNT_W-1:0] cyc;

  logic             load_ok;
  logic             load_bad;
  logic             at_boundary;
  logic [CNT_W-1:0] next_ratio;
  logic [CNT_W-1:0] cyc_inc;
  logic [CNT_W:0]   high_len;

  // Idle (stopped or just out of reset) behaves as a permanent period boundary.
  always_comb begin
    load_bad    = div_load && (div_val == ONE);
    load_ok     = div_load && (div_val != ONE);
    next_ratio  = load_ok ? div_val : shadow;
    at_boundary = (state != ST_RUN) || (cyc == div_active - ONE);
    cyc_inc     = cyc + ONE;
    high_len    = ({1'b0, div_active} + HW'(1)) >> 1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      div_pow <= '0;
    end else begin
      div_pow <= div_pow + STAGES'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= ST_IDLE;
      shadow      <= DEF_RATIO;
      div_active  <= DEF_RATIO;
      cyc         <= '0;
      prog_clk    <= 1'b0;
      prog_tick   <= 1'b0;
      div_pending <= 1'b0;
      div_err     <= 1'b0;
    end else begin
      div_err <= load_bad;
      shadow  <= next_ratio;
      if (at_boundary) begin
        div_active  <= next_ratio;
        div_pending <= 1'b0;
        if (next_ratio == '0) begin
          state     <= ST_IDLE;
          prog_clk  <= 1'b0;
          prog_tick <= 1'b0;
        end else begin
          state     <= ST_RUN;
          cyc       <= '0;
          prog_clk  <= 1'b1;
          prog_tick <= 1'b1;
        end
      end else begin
        cyc       <= cyc_inc;
        prog_tick <= 1'b0;
        prog_clk  <= ({1'b0, cyc_inc} < high_len);
        if (load_ok) begin
          div_pending <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_clk_divider_prog.sv
// Scoreboard bench for clk_divider_prog: expected output snapshots are queued as
// each cycle's stimulus is driven and compared one edge later.
module tb_clk_divider_prog;

  typedef struct packed {
    logic [3:0] pow;
    logic       pclk;
    logic       tick;
    logic       pend;
    logic       err;
    logic [7:0] act;
  } obs_t;

  logic       clk;
  logic       rst;
  logic [7:0] div_val;
  logic       div_load;
  logic [3:0] div_pow;
  logic       prog_clk;
  logic       prog_tick;
  logic       div_pending;
  logic       div_err;
  logic [7:0] div_active;

  logic       rst2;
  logic [3:0] val2;
  logic       load2;
  logic [1:0] pow2;
  logic       pclk2;
  logic       tick2;
  logic       pend2;
  logic       err2;
  logic [3:0] act2;

  obs_t exp_q[$];
  int   exp_pow = 0;
  int   n_run   = 0;
  int   n_fail  = 0;

  clk_divider_prog #(.STAGES(4), .CNT_W(8), .DEFAULT_DIV(4)) dut (
    .clk(clk), .rst(rst), .div_val(div_val), .div_load(div_load),
    .div_pow(div_pow), .prog_clk(prog_clk), .prog_tick(prog_tick),
    .div_pending(div_pending), .div_err(div_err), .div_active(div_active)
  );

  clk_divider_prog #(.STAGES(2), .CNT_W(4), .DEFAULT_DIV(4)) dut_small (
    .clk(clk), .rst(rst2), .div_val(val2), .div_load(load2),
    .div_pow(pow2), .prog_clk(pclk2), .prog_tick(tick2),
    .div_pending(pend2), .div_err(err2), .div_active(act2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected snapshot for ratio n in cycle c; n < 2 means the channel is quiet.
  function automatic obs_t mk(input int pw, input int n, input int c,
                              input bit pend, input bit err, input int act);
    obs_t o;
    o.pow  = 4'(pw);
    o.pclk = (n >= 2) && (c < (n + 1) / 2);
    o.tick = (n >= 2) && (c == 0);
    o.pend = pend;
    o.err  = err;
    o.act  = 8'(act);
    return o;
  endfunction

  function automatic obs_t obs1();
    return {div_pow, prog_clk, prog_tick, div_pending, div_err, div_active};
  endfunction

  function automatic obs_t obs2();
    return {2'b00, pow2, pclk2, tick2, pend2, err2, 4'b0000, act2};
  endfunction

  task automatic drive(input bit ld, input int v);
    div_load = ld;
    div_val  = 8'(v);
  endtask

  task automatic expect_next(input int n, input int c, input bit pend,
                             input bit err, input int act);
    exp_pow = rst ? (exp_pow + 1) % 16 : 0;
    exp_q.push_back(mk(exp_pow, n, c, pend, err, act));
  endtask

  task automatic test_reset();
    obs_t got, want;
    rst = 1'b0;
    drive(0, 0);
    for (int i = 0; i < 3; i++) begin
      expect_next(0, 0, 0, 0, 4);
      @(posedge clk); #1;
      want = exp_q.pop_front(); got = obs1(); n_run++;
      if (got !== want) begin
        n_fail++;
        $display("[TB] FAIL reset step %0d: got %h, expected %h", i, got, want);
      end
    end
    rst = 1'b1;
    for (int i = 0; i < 32; i++) begin
      expect_next(4, i % 4, 0, 0, 4);
      @(posedge clk); #1;
      want = exp_q.pop_front(); got = obs1(); n_run++;
      if (got !== want) begin
        n_fail++;
        $display("[TB] FAIL power_on_run step %0d: got %h, expected %h", i, got, want);
      end
    end
  endtask

  task automatic test_load5();
    obs_t got, want;
    for (int i = 0; i < 19; i++) begin
      drive(i == 2, 5);
      if (i < 4) expect_next(4, i, i >= 2, 0, 4);
      else       expect_next(5, (i - 4) % 5, 0, 0, 5);
      @(posedge clk); #1;
      want = exp_q.pop_front(); got = obs1(); n_run++;
      if (got !== want) begin
        n_fail++;
        $display("[TB] FAIL load5 step %0d: got %h, expected %h", i, got, want);
      end
    end
  endtask

  task automatic test_boundary();
    obs_t got, want;
    bit   ld;
    int   v;
    for (int i = 0; i < 23; i++) begin
      ld = 1'b1;
      v  = 0;
      case (i)
        0:       v = 4;
        2:       v = 7;
        3:       v = 9;
        13:      v = 4;
        17:      v = 6;
        default: ld = 1'b0;
      endcase
      drive(ld, v);
      if (i <= 3)       expect_next(4, i, i >= 2, 0, 4);
      else if (i <= 12) expect_next(9, i - 4, 0, 0, 9);
      else if (i <= 16) expect_next(4, i - 13, 0, 0, 4);
      else              expect_next(6, i - 17, 0, 0, 6);
      @(posedge clk); #1;
      want = exp_q.pop_front(); got = obs1(); n_run++;
      if (got !== want) begin
        n_fail++;
        $display("[TB] FAIL boundary step %0d: got %h, expected %h", i, got, want);
      end
    end
  endtask

  task automatic test_err_stop();
    obs_t got, want;
    bit   ld;
    int   v;
    for (int i = 0; i < 29; i++) begin
      ld = 1'b1;
      v  = 0;
      case (i)
        1:       v = 1;
        7:       v = 0;
        18:      v = 0;
        20:      v = 3;
        default: ld = 1'b0;
      endcase
      drive(ld, v);
      if (i <= 6)       expect_next(6, i % 6, 0, i == 1, 6);
      else if (i <= 11) expect_next(6, i - 6, 1, 0, 6);
      else if (i <= 19) expect_next(0, 0, 0, 0, 0);
      else              expect_next(3, (i - 20) % 3, 0, 0, 3);
      @(posedge clk); #1;
      want = exp_q.pop_front(); got = obs1(); n_run++;
      if (got !== want) begin
        n_fail++;
        $display("[TB] FAIL err_stop step %0d: got %h, expected %h", i, got, want);
      end
    end
  endtask

  task automatic test_reset_mid();
    obs_t got, want;
    for (int i = 0; i < 12; i++) begin
      rst = !(i == 2 || i == 3);
      drive(i == 1 || i == 2, (i == 1) ? 7 : 9);
      if (i <= 1)      expect_next(3, i, i == 1, 0, 3);
      else if (i <= 3) expect_next(0, 0, 0, 0, 4);
      else             expect_next(4, (i - 4) % 4, 0, 0, 4);
      @(posedge clk); #1;
      want = exp_q.pop_front(); got = obs1(); n_run++;
      if (got !== want) begin
        n_fail++;
        $display("[TB] FAIL reset_mid step %0d: got %h, expected %h", i, got, want);
      end
    end
    drive(0, 0);
  endtask

  task automatic test_small();
    obs_t got, want;
    rst2 = 1'b1;
    for (int i = 0; i < 34; i++) begin
      load2 = (i == 4);
      val2  = 4'd15;
      if (i < 4) exp_q.push_back(mk((i + 1) % 4, 4, i, 0, 0, 4));
      else       exp_q.push_back(mk((i + 1) % 4, 15, (i - 4) % 15, 0, 0, 15));
      @(posedge clk); #1;
      want = exp_q.pop_front(); got = obs2(); n_run++;
      if (got !== want) begin
        n_fail++;
        $display("[TB] FAIL small_div15 step %0d: got %h, expected %h", i, got, want);
      end
    end
    load2 = 1'b0;
  endtask

  initial begin
    rst      = 1'b0;
    div_load = 1'b0;
    div_val  = '0;
    rst2     = 1'b0;
    load2    = 1'b0;
    val2     = '0;
    test_reset();
    test_load5();
    test_boundary();
    test_err_stop();
    test_reset_mid();
    test_small();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete, %0d tests run", n_run);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
